// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
// Frame-level controller for the CNN datapath (conv window -> ReLU -> maxpool
// -> linear). It loads 64 pixels into the image buffer, then walks 36 output
// positions x 9 kernel taps while driving the accumulator strobes. It also
// holds the two-channel results in a small FIFO toward the consumer.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   global enable; low freezes every register
//   start, abort          frame begin (IDLE only) / abandon current frame
//   pix_valid             input pixel present
//   pix_we, pix_addr      image buffer write strobe and address
//   pos_x, pos_y, tap_idx current output position and kernel tap
//   acc_clr, acc_en       accumulator load-vs-add select and update strobe
//   pos_done              last tap of a position (datapath captures result)
//   res_in, res_in_valid  {ch1, ch0} result from the linear stage
//   res_data, res_valid   FIFO head toward the consumer
//   res_ready             consumer accepts head
//   state                 FSM state: IDLE=0 LOAD=1 CONV=2 DRAIN=3 FLUSH=4 DONE=5
//   overflow              sticky: push arrived while the FIFO was full
//
// Handshake: a result leaves the FIFO on any enabled cycle where
// res_valid && res_ready; res_data holds while res_valid && !res_ready.
module cnn_frame_sequencer #(
    parameter int IMG_W      = 8,
    parameter int OUT_W      = 6,
    parameter int TAPS       = 9,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic        abort,
    input  logic        pix_valid,
    output logic        pix_we,
    output logic [5:0]  pix_addr,
    output logic [2:0]  pos_x,
    output logic [2:0]  pos_y,
    output logic [3:0]  tap_idx,
    output logic        acc_clr,
    output logic        acc_en,
    output logic        pos_done,
    input  logic [15:0] res_in,
    input  logic        res_in_valid,
    output logic [15:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [2:0]  state,
    output logic        overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [5:0]       LAST_PIX = 6'(IMG_W * IMG_W - 1);
    localparam logic [2:0]       LAST_POS = 3'(OUT_W - 1);
    localparam logic [3:0]       LAST_TAP = 4'(TAPS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CONV  = 3'd2,
        S_DRAIN = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t cur, nxt;

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] occ;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [15:0]      mem [FIFO_DEPTH];

    logic abort_hit;
    logic credit_ok;
    logic push, pop, full, do_write;

    // Abort only acts on a frame in progress; it outranks every other event.
    assign abort_hit = ena && abort && (cur == S_LOAD || cur == S_CONV || cur == S_DRAIN);

    // A position may start only if its result is guaranteed a FIFO slot.
    assign credit_ok = ({1'b0, inflight} + {1'b0, occ}) < CREDITS;

    assign full      = (occ == CNT_FULL);
    assign res_valid = (occ != '0);
    assign res_data  = mem[rd_ptr];
    assign pop       = ena && res_valid && res_ready;
    // Results landing during FLUSH (or on the abort cycle) belong to the
    // abandoned frame and are dropped.
    assign push      = ena && res_in_valid && (cur != S_FLUSH) && !abort_hit;
    assign do_write  = push && (!full || pop);
    assign state     = cur;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        if (ena) begin
            if (abort_hit) begin
                nxt = S_FLUSH;
            end else begin
                case (cur)
                    S_IDLE:  if (start) nxt = S_LOAD;
                    S_LOAD:  if (pix_we && pix_addr == LAST_PIX) nxt = S_CONV;
                    S_CONV:  if (pos_done && pos_x == LAST_POS && pos_y == LAST_POS) nxt = S_DRAIN;
                    S_DRAIN: if (inflight == '0) nxt = S_DONE;
                    S_FLUSH: if (inflight == '0) nxt = S_IDLE;
                    S_DONE:  nxt = S_IDLE;
                    default: nxt = S_IDLE;
                endcase
            end
        end
    end

    // Output strobes; the stall check applies only at tap 0 so a started
    // position always runs its taps back to back.
    always_comb begin
        pix_we   = 1'b0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
        pos_done = 1'b0;
        if (ena && !abort_hit) begin
            case (cur)
                S_LOAD: pix_we = pix_valid;
                S_CONV: begin
                    if (tap_idx != 4'd0 || credit_ok) begin
                        acc_en   = 1'b1;
                        acc_clr  = (tap_idx == 4'd0);
                        pos_done = (tap_idx == LAST_TAP);
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel address, position and tap counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_addr <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            tap_idx  <= '0;
        end else if (ena) begin
            if (abort_hit || (cur == S_IDLE && start)) begin
                pix_addr <= '0;
                pos_x    <= '0;
                pos_y    <= '0;
                tap_idx  <= '0;
            end else begin
                if (pix_we)
                    pix_addr <= (pix_addr == LAST_PIX) ? 6'd0 : pix_addr + 6'd1;
                if (acc_en)
                    tap_idx <= (tap_idx == LAST_TAP) ? 4'd0 : tap_idx + 4'd1;
                if (pos_done) begin
                    if (pos_x == LAST_POS) begin
                        pos_x <= 3'd0;
                        pos_y <= (pos_y == LAST_POS) ? 3'd0 : pos_y + 3'd1;
                    end else begin
                        pos_x <= pos_x + 3'd1;
                    end
                end
            end
        end
    end

    // In-flight results: issued at pos_done, retired on res_in_valid.
    // Retirement continues through FLUSH so the frame can close cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (ena) begin
            case ({pos_done, res_in_valid})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   if (inflight != '0) inflight <= inflight - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Result FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (ena) begin
            if (abort_hit) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
            end else begin
                if (pop)
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                if (do_write) begin
                    mem[wr_ptr] <= res_in;
                    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (push && full && !pop)
                    overflow <= 1'b1;
                case ({do_write, pop})
                    2'b10:   occ <= occ + CNT_ONE;
                    2'b01:   occ <= occ - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Testbench for cnn_frame_sequencer. A reference model (queue of expected
// FIFO contents, schedule of pending linear-stage results, raster-order
// position index) checks the DUT cycle by cycle while directed frames
// exercise load, convolution, credit stall, enable freeze, abort and overflow.
module tb_cnn_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, ena, start, abort, pix_valid, res_in_valid, res_ready;
    logic [15:0] res_in;
    logic        pix_we, acc_clr, acc_en, pos_done, res_valid, overflow;
    logic [5:0]  pix_addr;
    logic [2:0]  pos_x, pos_y, state;
    logic [3:0]  tap_idx;
    logic [15:0] res_data;

    cnn_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_we(pix_we), .pix_addr(pix_addr),
        .pos_x(pos_x), .pos_y(pos_y), .tap_idx(tap_idx),
        .acc_clr(acc_clr), .acc_en(acc_en), .pos_done(pos_done),
        .res_in(res_in), .res_in_valid(res_in_valid),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .state(state), .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // reference model state
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          res_delay = 3;
    logic [15:0] exp_q[$];
    int          due_q[$];
    logic [15:0] dat_q[$];
    int          discard_n = 0;
    bit          exp_ovf   = 1'b0;
    bit          abort_arm = 1'b0;
    int          conv_n, done_n, flush_n, acc_en_n, acc_clr_n, pd_n, pop_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // drive the linear-stage result for this cycle, then check and update the model
    task automatic sample();
        logic [15:0] d;
        res_in_valid = 1'b0;
        res_in       = '0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            res_in_valid = 1'b1;
            res_in       = dat_q[0];
        end
        #1;
        chk("overflow", overflow, exp_ovf);
        chk("res_valid", res_valid, exp_q.size() != 0);
        if (!ena) chk("strobes_frozen", {pix_we, acc_en, acc_clr, pos_done}, 0);
        if (ena && res_ready && exp_q.size() > 0) begin
            chk("res_data", res_data, exp_q[0]);
            void'(exp_q.pop_front());
            pop_n++;
        end
        if (abort_arm) begin
            exp_q.delete();
            discard_n = due_q.size();
        end
        if (ena && res_in_valid) begin
            d = dat_q.pop_front();
            void'(due_q.pop_front());
            if (discard_n > 0)          discard_n--;
            else if (exp_q.size() >= 2) exp_ovf = 1'b1;
            else                        exp_q.push_back(d);
        end
        if (ena && pos_done) begin
            chk("pos_x_order", pos_x, pd_n % 6);
            chk("pos_y_order", pos_y, pd_n / 6);
            pd_n++;
            due_q.push_back(cyc + res_delay);
            dat_q.push_back(16'($urandom));
        end
        if (state == 3'd2) conv_n++;
        if (state == 3'd4) flush_n++;
        if (state == 3'd5) done_n++;
        if (acc_en)  acc_en_n++;
        if (acc_clr) acc_clr_n++;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    // driver tasks
    task automatic start_frame();
        conv_n = 0; done_n = 0; flush_n = 0; acc_en_n = 0; acc_clr_n = 0; pd_n = 0; pop_n = 0;
        start = 1'b1;
        sample();
        chk("idle_before_start", state, 0);
        tick();
        start = 1'b0;
    endtask

    task automatic load_pixels(input bit toggle);
        int k = 0;
        int i = 0;
        while (k < 64 && i < 300) begin
            pix_valid = toggle ? (i % 2 == 0) : 1'b1;
            sample();
            chk("state_load", state, 1);
            chk("pix_we", pix_we, pix_valid);
            if (pix_valid) begin
                chk("pix_addr", pix_addr, k);
                k++;
            end
            tick();
            i++;
        end
        pix_valid = 1'b0;
        chk("load_cycles", i, toggle ? 127 : 64);
    endtask

    task automatic run_to_idle(input int bound);
        int n = 0;
        bit seen_idle = 1'b0;
        while (!seen_idle && n < bound) begin
            sample();
            seen_idle = (state == 3'd0);
            tick();
            n++;
        end
        chk("frame_returns_idle", seen_idle, 1);
    endtask

    task automatic frame_checks();
        chk("pos_done_count", pd_n, 36);
        chk("acc_en_count", acc_en_n, 324);
        chk("acc_clr_count", acc_clr_n, 36);
        chk("done_cycles", done_n, 1);
        chk("results_out", pop_n, 36);
    endtask

    task automatic inject(input logic [15:0] d);
        due_q.push_back(cyc);
        dat_q.push_back(d);
        step();
    endtask

    // directed sequence
    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0;
        res_in_valid = 1'b0; res_in = '0; res_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_pix_addr", pix_addr, 0);
        chk("rst_pos", {pos_x, pos_y, tap_idx}, 0);
        chk("rst_strobes", {pix_we, acc_en, acc_clr, pos_done}, 0);
        chk("rst_res", {res_valid, res_data, overflow}, 0);
        rst_n = 1'b1;
        tick();

        // frame A: continuous pixels, results 3 cycles after each pos_done
        start_frame();
        load_pixels(1'b0);
        run_to_idle(1000);
        chk("conv_cycles_a", conv_n, 324);
        frame_checks();

        // abort in IDLE has no effect
        abort = 1'b1;
        step();
        abort = 1'b0;
        sample();
        chk("abort_in_idle", state, 0);
        tick();

        // frame B: pixel every other cycle
        start_frame();
        load_pixels(1'b1);
        run_to_idle(1000);
        chk("conv_cycles_b", conv_n, 324);
        frame_checks();

        // frame C: consumer stalled, credit gate holds position 2 at tap 0
        res_ready = 1'b0;
        start_frame();
        load_pixels(1'b0);
        repeat (200) step();
        sample();
        chk("stall_state", state, 2);
        chk("stall_pos", {pos_x, pos_y, tap_idx}, {3'd2, 3'd0, 4'd0});
        chk("stall_acc_en", acc_en, 0);
        chk("stall_pos_done_count", pd_n, 2);
        chk("stall_res_valid", res_valid, 1);
        chk("stall_head_held", res_data, exp_q[0]);
        tick();
        res_ready = 1'b1;
        run_to_idle(1000);
        frame_checks();

        // frame D: ena low for 5 cycles at position (1,0) tap 4
        start_frame();
        load_pixels(1'b0);
        repeat (13) step();
        ena = 1'b0;
        repeat (5) begin
            sample();
            chk("frozen_state", state, 2);
            chk("frozen_pos", {pos_x, pos_y, tap_idx}, {3'd1, 3'd0, 4'd4});
            tick();
        end
        ena = 1'b1;
        sample();
        chk("resume_tap", tap_idx, 4);
        chk("resume_acc_en", acc_en, 1);
        tick();
        run_to_idle(1000);
        chk("conv_cycles_d", conv_n, 329);
        frame_checks();

        // frame E: abort at (2,3) tap 6 with one result still in flight
        res_delay = 8;
        start_frame();
        load_pixels(1'b0);
        repeat (186) step();
        abort = 1'b1;
        abort_arm = 1'b1;
        sample();
        chk("abort_point", {state, pos_x, pos_y, tap_idx}, {3'd2, 3'd2, 3'd3, 4'd6});
        tick();
        abort = 1'b0;
        abort_arm = 1'b0;
        sample();
        chk("flush_state", state, 4);
        chk("flush_counters", {pix_addr, pos_x, pos_y, tap_idx}, 0);
        tick();
        run_to_idle(40);
        chk("flush_cycles", flush_n, 2);
        chk("flush_inflight_discarded", due_q.size() + discard_n, 0);

        // frame F: clean frame after abort
        res_delay = 3;
        start_frame();
        load_pixels(1'b0);
        run_to_idle(1000);
        chk("conv_cycles_f", conv_n, 324);
        frame_checks();

        // overflow: fill FIFO, push+pop at full, then push at full without pop
        res_ready = 1'b0;
        inject(16'($urandom));
        inject(16'($urandom));
        res_ready = 1'b1;
        inject(16'($urandom));
        res_ready = 1'b0;
        sample();
        chk("no_ovf_on_pushpop", overflow, 0);
        chk("full_valid", res_valid, 1);
        tick();
        inject(16'($urandom));
        repeat (3) step();
        sample();
        chk("ovf_sticky", overflow, 1);
        tick();
        res_ready = 1'b1;
        repeat (3) step();
        sample();
        chk("drained_after_ovf", res_valid, 0);
        chk("ovf_still_set", overflow, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("ovf_cleared_by_reset", overflow, 0);
        chk("reset_state_again", state, 0);
        exp_ovf = 1'b0;
        exp_q.delete();
        due_q.delete();
        dat_q.delete();
        rst_n = 1'b1;
        tick();
        step();

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
